tcdm_bank_adapter: RTL and testbench

TCDM_BANK_ADAPTER -- requirements
Module: tcdm_bank_adapter

---
 rtl/tcdm_bank_adapter.sv | 226 ++++++++++++++++++++++
 tb/tb_tcdm_bank_adapter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_bank_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tcdm_bank_adapter
// Purpose  : Bridges a TCDM request/response channel onto a single-port SRAM
//            bank, buffering read responses in a credit-guarded FIFO.
//            Optional LR/SC reservation logic: define TCDM_ADAPTER_LRSC_EN.
// Revision : 1.0 - initial release
// ============================================================================

package tcdm_bank_adapter_pkg;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  amo;
    logic [7:0]  meta_id;
    logic [7:0]  core_id;
  } tcdm_payload_t;

  typedef struct packed {
    tcdm_payload_t wdata;
    logic          wen;
    logic [3:0]    be;
    logic [31:0]   tgt_addr;
    logic [7:0]    ini_addr;
  } tcdm_slave_req_t;

  typedef struct packed {
    tcdm_payload_t rdata;
    logic [7:0]    ini_addr;
  } tcdm_slave_resp_t;

  localparam logic [3:0] c_amo_lr = 4'hA;
  localparam logic [3:0] c_amo_sc = 4'hB;

endpackage

module tcdm_bank_adapter
  import tcdm_bank_adapter_pkg::*;
#(
  parameter int unsigned AddrMemWidth = 8,
  parameter int unsigned RespDepth    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  tcdm_slave_req_t         in_req_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output tcdm_slave_resp_t        out_resp_o,
  output logic                    bank_req_o,
  output logic                    bank_we_o,
  output logic [AddrMemWidth-1:0] bank_addr_o,
  output logic [31:0]             bank_wdata_o,
  output logic [3:0]              bank_be_o,
  input  logic [31:0]             bank_rdata_i
);

  localparam int unsigned       c_cnt_w = $clog2(RespDepth + 1);
  localparam int unsigned       c_ptr_w = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(RespDepth);
  localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(RespDepth - 1);

  logic [c_cnt_w-1:0]    credits;
  logic [c_cnt_w-1:0]    fifo_cnt;
  logic [c_ptr_w-1:0]    rd_ptr;
  logic [c_ptr_w-1:0]    wr_ptr;
  tcdm_slave_resp_t      mem [RespDepth];
  logic                  pipe_valid;
  tcdm_slave_resp_t      pipe_meta;
  tcdm_slave_resp_t      pipe_entry;
  logic                  fifo_empty;
  logic                  drain;
  logic                  push;
  logic                  pop;
  logic                  accept;
  logic                  take_credit;
  logic                  write_en;
  logic                  produces_resp;
  logic [AddrMemWidth-1:0] req_addr;

  assign req_addr = in_req_i.tgt_addr[AddrMemWidth-1:0];

  generate
    if (AddrMemWidth < 32) begin : g_addr_unused
      logic unused_addr_bits;
      assign unused_addr_bits = ^in_req_i.tgt_addr[31:AddrMemWidth];
    end
  endgenerate

`ifdef TCDM_ADAPTER_LRSC_EN
  logic                    res_valid;
  logic [7:0]              res_ini;
  logic [7:0]              res_core;
  logic [AddrMemWidth-1:0] res_addr;
  logic                    is_lr;
  logic                    is_sc;
  logic                    res_addr_hit;
  logic                    sc_ok;
  logic                    pipe_sc;
  logic                    pipe_sc_fail;

  assign is_lr         = (in_req_i.wdata.amo == c_amo_lr);
  assign is_sc         = in_req_i.wen && (in_req_i.wdata.amo == c_amo_sc);
  assign res_addr_hit  = res_valid && (res_addr == req_addr);
  assign sc_ok         = res_addr_hit && (res_ini == in_req_i.ini_addr) &&
                         (res_core == in_req_i.wdata.core_id);
  assign write_en      = in_req_i.wen && !is_lr && (!is_sc || sc_ok);
  assign produces_resp = !in_req_i.wen || is_lr || is_sc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_valid <= 1'b0;
      res_ini   <= '0;
      res_core  <= '0;
      res_addr  <= '0;
    end else if (accept) begin
      if (is_lr) begin
        res_valid <= 1'b1;
        res_ini   <= in_req_i.ini_addr;
        res_core  <= in_req_i.wdata.core_id;
        res_addr  <= req_addr;
      end else if (is_sc || (in_req_i.wen && res_addr_hit)) begin
        res_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_sc      <= 1'b0;
      pipe_sc_fail <= 1'b0;
    end else if (take_credit) begin
      pipe_sc      <= is_sc;
      pipe_sc_fail <= !sc_ok;
    end
  end

  // SC responses carry the success flag (0 = stored) instead of bank data.
  always_comb begin
    pipe_entry            = pipe_meta;
    pipe_entry.rdata.data = pipe_sc ? {31'b0, pipe_sc_fail} : bank_rdata_i;
  end
`else
  assign write_en      = in_req_i.wen;
  assign produces_resp = !in_req_i.wen;

  always_comb begin
    pipe_entry            = pipe_meta;
    pipe_entry.rdata.data = bank_rdata_i;
  end
`endif

  assign fifo_empty  = (fifo_cnt == '0);
  assign out_valid_o = !fifo_empty || pipe_valid;
  assign out_resp_o  = fifo_empty ? pipe_entry : mem[rd_ptr];
  assign drain       = out_valid_o && out_ready_i;
  assign pop         = drain && !fifo_empty;
  assign push        = pipe_valid && !(fifo_empty && out_ready_i);

  // A response leaving this cycle frees its credit for a same-cycle request.
  assign in_ready_o  = !rst_i && ((credits < c_depth) || drain);
  assign accept      = in_valid_i && in_ready_o;
  assign take_credit = accept && produces_resp;

  assign bank_req_o   = accept;
  assign bank_we_o    = accept && write_en;
  assign bank_addr_o  = accept ? req_addr : '0;
  assign bank_wdata_o = accept ? in_req_i.wdata.data : '0;
  assign bank_be_o    = accept ? in_req_i.be : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credits <= '0;
    end else if (take_credit && !drain) begin
      credits <= credits + 1'b1;
    end else if (drain && !take_credit) begin
      credits <= credits - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_valid <= 1'b0;
      pipe_meta  <= '0;
    end else begin
      pipe_valid <= take_credit;
      if (take_credit) begin
        pipe_meta.rdata.data    <= '0;
        pipe_meta.rdata.amo     <= in_req_i.wdata.amo;
        pipe_meta.rdata.meta_id <= in_req_i.wdata.meta_id;
        pipe_meta.rdata.core_id <= in_req_i.wdata.core_id;
        pipe_meta.ini_addr      <= in_req_i.ini_addr;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == c_last) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == c_last) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + 1'b1;
      end else if (pop && !push) begin
        fifo_cnt <= fifo_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= pipe_entry;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tcdm_bank_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcdm_bank_adapter
// Purpose  : Directed plus randomized checks of tcdm_bank_adapter against a
//            transaction-level model (memory image + response queue).
// Revision : 1.0 - initial release
// ============================================================================

module tb_tcdm_bank_adapter;
  import tcdm_bank_adapter_pkg::*;

  localparam int D  = 2;
  localparam int AW = 8;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             in_valid_i;
  logic             in_ready_o;
  tcdm_slave_req_t  in_req_i;
  logic             out_valid_o;
  logic             out_ready_i;
  tcdm_slave_resp_t out_resp_o;
  logic             bank_req_o;
  logic             bank_we_o;
  logic [AW-1:0]    bank_addr_o;
  logic [31:0]      bank_wdata_o;
  logic [3:0]       bank_be_o;
  logic [31:0]      bank_rdata_i;

  tcdm_bank_adapter #(.AddrMemWidth(AW), .RespDepth(D)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_req_i     (in_req_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_resp_o   (out_resp_o),
    .bank_req_o   (bank_req_o),
    .bank_we_o    (bank_we_o),
    .bank_addr_o  (bank_addr_o),
    .bank_wdata_o (bank_wdata_o),
    .bank_be_o    (bank_be_o),
    .bank_rdata_i (bank_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // SRAM bank driven by the DUT's bank port.
  logic [31:0] bank_mem [256];
  always @(posedge clk_i) begin
    if (bank_req_o) begin
      if (bank_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bank_be_o[b]) bank_mem[bank_addr_o][8*b +: 8] <= bank_wdata_o[8*b +: 8];
      end else begin
        bank_rdata_i <= bank_mem[bank_addr_o];
      end
    end
  end

  // Reference model: memory image, outstanding responses, reservation.
  logic [31:0]      ref_mem [256];
  tcdm_slave_resp_t exp_q [$];
  logic             res_v;
  logic [7:0]       res_ini, res_core, res_addr;
  int               n_assert = 0;
  int               n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic tcdm_slave_req_t mk(input logic wen, input logic [31:0] addr,
                                         input logic [31:0] data, input logic [3:0] be,
                                         input logic [3:0] amo, input logic [7:0] ini,
                                         input logic [7:0] core);
    tcdm_slave_req_t r;
    r.wdata.data    = data;
    r.wdata.amo     = amo;
    r.wdata.meta_id = 8'($urandom);
    r.wdata.core_id = core;
    r.wen           = wen;
    r.be            = be;
    r.tgt_addr      = addr;
    r.ini_addr      = ini;
    return r;
  endfunction

  function automatic tcdm_slave_req_t rand_req();
    logic [31:0] addr;
    logic [3:0]  amo;
    addr = $urandom;
    case ($urandom_range(0, 3))
      0:       addr[7:0] = 8'h10;
      1:       addr[7:0] = 8'h11;
      2:       addr[7:0] = 8'h05;
      default: addr[7:0] = 8'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0:       amo = 4'hA;
      1:       amo = 4'hB;
      default: amo = 4'($urandom_range(0, 9));
    endcase
    return mk(1'($urandom), addr, $urandom, 4'($urandom), amo,
              8'($urandom_range(0, 1)), 8'($urandom_range(0, 1)));
  endfunction

  // One clock cycle: drive, check against the model at mid-cycle, advance.
  task automatic step(input logic v, input tcdm_slave_req_t r, input logic ordy);
    logic             exp_rdy, acc, produces, we_exp;
    logic [7:0]       a;
    logic [31:0]      rdat;
    tcdm_slave_resp_t e;
    in_valid_i  = v;
    in_req_i    = r;
    out_ready_i = ordy;
    #4;
    exp_rdy = (exp_q.size() < D) || (exp_q.size() > 0 && ordy);
    check("in_ready", in_ready_o, exp_rdy);
    check("out_valid", out_valid_o, exp_q.size() > 0);
    if (exp_q.size() > 0) check("out_resp", out_resp_o, exp_q[0]);
    acc      = v && exp_rdy;
    a        = r.tgt_addr[7:0];
    produces = !r.wen;
    we_exp   = r.wen;
    rdat     = ref_mem[a];
    check("bank_req", bank_req_o, acc);
    if (acc) begin
`ifdef TCDM_ADAPTER_LRSC_EN
      if (r.wdata.amo == 4'hA) begin
        produces = 1'b1;
        we_exp   = 1'b0;
        res_v    = 1'b1;
        res_ini  = r.ini_addr;
        res_core = r.wdata.core_id;
        res_addr = a;
      end else if (r.wen && r.wdata.amo == 4'hB) begin
        we_exp   = res_v && res_ini == r.ini_addr && res_core == r.wdata.core_id && res_addr == a;
        produces = 1'b1;
        rdat     = {31'b0, !we_exp};
        res_v    = 1'b0;
      end else if (r.wen && res_v && res_addr == a) begin
        res_v = 1'b0;
      end
`endif
      check("bank_we", bank_we_o, we_exp);
      check("bank_addr", bank_addr_o, a);
      check("bank_wdata", bank_wdata_o, r.wdata.data);
      check("bank_be", bank_be_o, r.be);
      if (we_exp)
        for (int b = 0; b < 4; b++)
          if (r.be[b]) ref_mem[a][8*b +: 8] = r.wdata.data[8*b +: 8];
    end else begin
      check("bank_idle", {bank_we_o, bank_addr_o, bank_wdata_o, bank_be_o}, '0);
    end
    if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
    if (acc && produces) begin
      e.rdata          = r.wdata;
      e.rdata.data     = rdat;
      e.ini_addr       = r.ini_addr;
      exp_q.push_back(e);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic async_reset();
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_in_ready", in_ready_o, 1'b0);
    check("rst_bank_req", bank_req_o, 1'b0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    res_v = 1'b0;
  endtask

  tcdm_slave_req_t idle;

  initial begin
    rst_i        = 1'b1;
    in_valid_i   = 1'b1;
    out_ready_i  = 1'b0;
    res_v        = 1'b0;
    res_ini      = '0;
    res_core     = '0;
    res_addr     = '0;
    bank_rdata_i = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]  = $urandom;
      bank_mem[i] = ref_mem[i];
    end
    idle     = mk(1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 8'h0, 8'h0);
    in_req_i = mk(1'b0, 32'h5, 32'h0, 4'hF, 4'h0, 8'h0, 8'h0);
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_in_ready", in_ready_o, 1'b0);
    check("reset_out_valid", out_valid_o, 1'b0);
    check("reset_bank", {bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o, bank_be_o}, '0);
    rst_i = 1'b0;

    // Write then read back with initiator metadata.
    step(1'b1, mk(1'b1, 32'h5, 32'hDEADBEEF, 4'hF, 4'h0, 8'h0, 8'h0), 1'b1);
    step(1'b1, mk(1'b0, 32'h5, 32'h0, 4'h0, 4'h0, 8'h1, 8'h2), 1'b0);
    check("rd_valid", out_valid_o, 1'b1);
    check("rd_data", out_resp_o.rdata.data, 32'hDEADBEEF);
    check("rd_ini", out_resp_o.ini_addr, 8'h1);
    check("rd_core", out_resp_o.rdata.core_id, 8'h2);
    step(1'b0, idle, 1'b1);

    // Backpressure: third read stalls, then drains with a same-cycle accept.
    step(1'b1, mk(1'b0, 32'h1, 32'h0, 4'h0, 4'h0, 8'h0, 8'h0), 1'b0);
    step(1'b1, mk(1'b0, 32'h2, 32'h0, 4'h0, 4'h0, 8'h0, 8'h1), 1'b0);
    step(1'b1, mk(1'b0, 32'h3, 32'h0, 4'h0, 4'h0, 8'h1, 8'h0), 1'b0);
    step(1'b1, mk(1'b0, 32'h3, 32'h0, 4'h0, 4'h0, 8'h1, 8'h0), 1'b0);
    step(1'b1, mk(1'b0, 32'h3, 32'h0, 4'h0, 4'h0, 8'h1, 8'h0), 1'b1);
    step(1'b1, mk(1'b0, 32'h4, 32'h0, 4'h0, 4'h0, 8'h1, 8'h1), 1'b1);
    repeat (3) step(1'b0, idle, 1'b1);

    // Reset with two buffered responses.
    step(1'b1, mk(1'b0, 32'h6, 32'h0, 4'h0, 4'h0, 8'h0, 8'h0), 1'b0);
    step(1'b1, mk(1'b0, 32'h7, 32'h0, 4'h0, 4'h0, 8'h0, 8'h0), 1'b0);
    async_reset();
    step(1'b0, idle, 1'b1);

`ifdef TCDM_ADAPTER_LRSC_EN
    step(1'b1, mk(1'b0, 32'h10, 32'h0, 4'h0, 4'hA, 8'h1, 8'h1), 1'b1);
    step(1'b1, mk(1'b1, 32'h10, 32'hCAFE0001, 4'hF, 4'hB, 8'h1, 8'h1), 1'b1);
    check("sc_ok_data", out_resp_o.rdata.data, 32'h0);
    step(1'b1, mk(1'b1, 32'h10, 32'hCAFE0002, 4'hF, 4'hB, 8'h1, 8'h1), 1'b1);
    check("sc_fail_data", out_resp_o.rdata.data, 32'h1);
    step(1'b1, mk(1'b0, 32'h10, 32'h0, 4'h0, 4'hA, 8'h1, 8'h1), 1'b1);
    step(1'b1, mk(1'b1, 32'h10, 32'h12345678, 4'hF, 4'h0, 8'h0, 8'h0), 1'b1);
    step(1'b1, mk(1'b1, 32'h10, 32'hCAFE0003, 4'hF, 4'hB, 8'h1, 8'h1), 1'b1);
    check("sc_after_wr", out_resp_o.rdata.data, 32'h1);
    step(1'b1, mk(1'b0, 32'h10, 32'h0, 4'h0, 4'h0, 8'h0, 8'h0), 1'b1);
    check("sc_mem", out_resp_o.rdata.data, 32'h12345678);
`else
    step(1'b1, mk(1'b1, 32'h10, 32'hCAFE0001, 4'hF, 4'hB, 8'h1, 8'h1), 1'b1);
    check("sc_no_resp", out_valid_o, 1'b0);
`endif
    step(1'b0, idle, 1'b1);

    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) != 0), rand_req(), 1'($urandom_range(0, 2) != 0));
    repeat (D + 2) step(1'b0, idle, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
